// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: pattern encodings and per-pattern step range.
package led_seq_pkg;

    localparam logic [1:0] MODE_FILL   = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // Index of the final step of a pattern before it wraps back to 0.
    function automatic int unsigned last_step(logic [1:0] mode, int unsigned n);
        int unsigned last;
        case (mode)
            MODE_FILL:   last = 2 * n - 1;
            MODE_RUN:    last = n - 1;
            MODE_BOUNCE: last = 2 * n - 3;
            default:     last = 1;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Control/status bundle between a controller and the LED sequencer.
interface led_sequencer_if #(
    parameter int unsigned N_LEDS = 4
) ();

    logic                          en;
    logic [1:0]                    mode;
    logic [N_LEDS-1:0]             leds;
    logic [$clog2(2*N_LEDS)-1:0]   step;
    logic                          step_tick;

    modport master (
        output en,
        output mode,
        input  leds,
        input  step,
        input  step_tick
    );

    modport slave (
        input  en,
        input  mode,
        output leds,
        output step,
        output step_tick
    );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled clk cycles.
module led_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 while enabled; clr restarts the period regardless of en.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled step counter plus registered frame decode.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LEDS     = 4,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic            clk,
    input logic            rst,
    led_sequencer_if.slave bus
);

    localparam int unsigned       SW  = $clog2(2 * N_LEDS);
    localparam logic [N_LEDS-1:0] POL = {N_LEDS{ACTIVE_LOW}};

    logic [1:0]        mode_q;
    logic [SW-1:0]     step_q, step_d;
    logic [SW-1:0]     step_last;
    logic              adv_q, adv_d;
    logic              step_tick_q;
    logic [N_LEDS-1:0] leds_q;
    logic              tick;
    logic              restart;

    // Logical-on vector for step s of pattern m; out-of-range steps light nothing sensible.
    function automatic logic [N_LEDS-1:0] frame_of(logic [1:0] m, logic [SW-1:0] s);
        logic [N_LEDS-1:0] f;
        int unsigned       si;
        int unsigned       p;
        f  = '0;
        si = 32'(s);
        if (si < N_LEDS) begin
            p = si;
        end else if (si <= 2 * N_LEDS - 2) begin
            p = 2 * N_LEDS - 2 - si;
        end else begin
            p = N_LEDS;
        end
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            case (m)
                MODE_FILL:   f[i] = (si <= N_LEDS) ? (i < si) : (i >= si - N_LEDS);
                MODE_RUN:    f[i] = (i == si);
                MODE_BOUNCE: f[i] = (i == p);
                default:     f[i] = (si == 1);
            endcase
        end
        return f;
    endfunction

    assign restart   = (bus.mode != mode_q);
    assign step_last = SW'(last_step(mode_q, N_LEDS));

    led_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (restart),
        .tick (tick)
    );

    // Next step: a mode change restarts at 0 and wins over a coincident tick.
    always_comb begin
        step_d = step_q;
        adv_d  = 1'b0;
        if (restart) begin
            step_d = '0;
        end else if (tick) begin
            adv_d  = 1'b1;
            step_d = (step_q >= step_last) ? '0 : step_q + SW'(1);
        end
    end

    // State and outputs; leds and step_tick trail the step register by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= bus.mode;
            step_q      <= '0;
            adv_q       <= 1'b0;
            step_tick_q <= 1'b0;
            leds_q      <= POL;
        end else begin
            mode_q      <= bus.mode;
            step_q      <= step_d;
            adv_q       <= adv_d;
            step_tick_q <= adv_q;
            leds_q      <= frame_of(mode_q, step_q) ^ POL;
        end
    end

    assign bus.leds      = leds_q;
    assign bus.step      = step_q;
    assign bus.step_tick = step_tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench: three sequencer instances (FILL/BLINK/mode-switch, RUN active-high, BOUNCE N=5).
module tb_led_sequencer;
    import led_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    led_sequencer_if #(.N_LEDS(4)) if_a ();
    led_sequencer_if #(.N_LEDS(4)) if_b ();
    led_sequencer_if #(.N_LEDS(5)) if_c ();

    led_sequencer #(.N_LEDS(4), .TICK_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    led_sequencer #(.N_LEDS(4), .TICK_DIV(4), .ACTIVE_LOW(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    led_sequencer #(.N_LEDS(5), .TICK_DIV(4), .ACTIVE_LOW(1'b1)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedges until dut_a pulses step_tick; -1 if none within the budget.
    task automatic wait_tick_a(output int n);
        n = -1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (if_a.step_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    logic [3:0] exp_fill   [9];
    logic [2:0] exp_fstep  [9];
    logic [3:0] exp_run    [9];
    logic [4:0] exp_bounce [9];
    int         n;
    int         seen;

    initial begin
        exp_fill   = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111,
                       4'b1111, 4'b1110};
        exp_fstep  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        exp_run    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                       4'b0001, 4'b0010};
        exp_bounce = '{5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b10111, 5'b11011,
                       5'b11101, 5'b11110, 5'b11101};
        n_asserts = 0;
        n_fail    = 0;

        // Reset with all instances configured.
        rst       = 1'b1;
        if_a.en   = 1'b1;
        if_a.mode = MODE_FILL;
        if_b.en   = 1'b1;
        if_b.mode = MODE_RUN;
        if_c.en   = 1'b1;
        if_c.mode = MODE_BOUNCE;
        repeat (3) @(negedge clk);
        check("rst_a_leds", 32'(if_a.leds), 32'h0f);
        check("rst_a_step", 32'(if_a.step), 32'h0);
        check("rst_a_tick", 32'(if_a.step_tick), 32'h0);
        check("rst_b_leds", 32'(if_b.leds), 32'h0);
        check("rst_c_leds", 32'(if_c.leds), 32'h1f);
        rst = 1'b0;

        // Free run: all three advance in lockstep.
        for (int k = 0; k < 9; k++) begin
            wait_tick_a(n);
            check($sformatf("tick_gap[%0d]", k), 32'(n), (k == 0) ? 32'd5 : 32'd4);
            check($sformatf("fill_leds[%0d]", k), 32'(if_a.leds), 32'(exp_fill[k]));
            check($sformatf("fill_step[%0d]", k), 32'(if_a.step), 32'(exp_fstep[k]));
            check($sformatf("run_leds[%0d]", k), 32'(if_b.leds), 32'(exp_run[k]));
            check($sformatf("run_step[%0d]", k), 32'(if_b.step), 32'((k + 1) % 4));
            check($sformatf("bounce_leds[%0d]", k), 32'(if_c.leds), 32'(exp_bounce[k]));
            check($sformatf("bounce_step[%0d]", k), 32'(if_c.step), 32'((k + 1) % 8));
        end

        // BLINK, then freeze mid-period.
        if_a.mode = MODE_BLINK;
        @(negedge clk);
        check("blink_rst_step", 32'(if_a.step), 32'h0);
        check("blink_rst_tick", 32'(if_a.step_tick), 32'h0);
        @(negedge clk);
        check("blink_f0_leds", 32'(if_a.leds), 32'h0f);
        wait_tick_a(n);
        check("blink_gap", 32'(n), 32'd4);
        check("blink_f1_leds", 32'(if_a.leds), 32'h0);
        check("blink_f1_step", 32'(if_a.step), 32'h1);
        @(negedge clk);
        if_a.en = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_a.step_tick === 1'b1) seen++;
        end
        check("frz_ticks", 32'(seen), 32'd0);
        check("frz_leds", 32'(if_a.leds), 32'h0);
        check("frz_step", 32'(if_a.step), 32'h1);
        check("frz_cnt", 32'(dut_a.u_tick.cnt), 32'd2);
        if_a.en = 1'b1;
        wait_tick_a(n);
        check("resume_gap", 32'(n), 32'd3);
        check("resume_leds", 32'(if_a.leds), 32'h0f);
        check("resume_step", 32'(if_a.step), 32'h0);

        // RUN, then switch to FILL on the very cycle a tick is due.
        if_a.mode = MODE_RUN;
        wait_tick_a(n);
        check("run_a_gap", 32'(n), 32'd6);
        check("run_a_leds", 32'(if_a.leds), 32'h0d);
        check("run_a_step", 32'(if_a.step), 32'h1);
        repeat (2) @(negedge clk);
        if_a.mode = MODE_FILL;
        @(negedge clk);
        check("sw_step", 32'(if_a.step), 32'h0);
        check("sw_tick0", 32'(if_a.step_tick), 32'h0);
        @(negedge clk);
        check("sw_leds", 32'(if_a.leds), 32'h0f);
        check("sw_tick1", 32'(if_a.step_tick), 32'h0);
        wait_tick_a(n);
        check("sw_gap", 32'(n), 32'd4);
        check("sw_next_leds", 32'(if_a.leds), 32'h0e);
        check("sw_next_step", 32'(if_a.step), 32'h1);

        // Reset in the middle of the drain phase.
        for (int k = 0; k < 4; k++) wait_tick_a(n);
        check("pre_rst_gap", 32'(n), 32'd4);
        check("pre_rst_step", 32'(if_a.step), 32'h5);
        check("pre_rst_leds", 32'(if_a.leds), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_leds", 32'(if_a.leds), 32'h0f);
        check("mid_rst_step", 32'(if_a.step), 32'h0);
        check("mid_rst_tick", 32'(if_a.step_tick), 32'h0);
        check("mid_rst_cnt", 32'(dut_a.u_tick.cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
